dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter N, default 64, data and address width.
REQ-002 Parameter DEPTH, default 64, number of N-bit words in storage; a power of two.
REQ-003 Parameter LATENCY, default 2, number of ACCESS-state cycles per request (1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 memRead  input  1  load request from the memory stage.
REQ-007 memWrite  input  1  store request from the memory stage.
REQ-008 address  input  N  byte address (execute-stage ALU result).
REQ-009 writeData  input  N  store data (execute-stage register operand 2).
REQ-010 readData  output  N  load result, valid while done=1.
REQ-011 stall  output  1  pipeline freeze request while an access is outstanding.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 misalign  output  1  one-cycle misaligned-access flag, coincident with done.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; reset state IDLE.
- IDLE: memRead|memWrite=1 -> ACCESS.
- ACCESS: after LATENCY cycles -> RESP.
- RESP: -> IDLE unconditionally.
REQ-015 In IDLE with memRead|memWrite=1, the block SHALL latch address, writeData and request type, load the cycle counter with LATENCY-1, and assert stall combinationally in that same cycle.
REQ-016 stall SHALL be 1 when (IDLE and a request is present) or the state is ACCESS; otherwise 0.
REQ-017 The counter SHALL decrement once per ACCESS cycle; leaving ACCESS at count 0 SHALL take exactly LATENCY cycles.
REQ-018 Total request latency SHALL be LATENCY+1 cycles from the request cycle to the done cycle.
REQ-019 Word index SHALL be latched address[$clog2(DEPTH)+2:3]; higher address bits are ignored, so addresses wrap modulo DEPTH*8.
REQ-020 A store SHALL commit to storage on the final ACCESS cycle edge; readData SHALL be 0 during RESP for stores.
REQ-021 A load SHALL present the stored word on readData during RESP; readData SHALL be 0 in all other states.
REQ-022 If memRead and memWrite are both 1, the request SHALL be treated as a store.
REQ-023 Input changes during ACCESS/RESP SHALL be ignored; inputs are sampled only in IDLE.
REQ-024 The request seen in the RESP cycle is the completed one; the next request is accepted only from the following IDLE cycle, so back-to-back requests incur no extra bubble beyond RESP.

Reset
REQ-025 While reset=0: state IDLE, counter 0, stall=0, done=0, misalign=0, readData=0, latched registers cleared.
REQ-026 Reset asserted mid-ACCESS SHALL abort the request with no store committed; storage contents are never cleared by reset.

Configuration
REQ-027 Macro DMEM_ALIGN_CHECK_EN: when defined, a request with latched address[2:0]!=0 SHALL commit no store, return readData=0, and assert misalign together with done; timing is unchanged.
REQ-028 Without DMEM_ALIGN_CHECK_EN, misalign SHALL be tied to 0 and address[2:0] ignored; the port list is identical in both builds.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum typedef (IDLE, ACCESS, RESP) and the default LATENCY and DEPTH constants.
REQ-030 Storage SHALL be a sub-module dmem_ram (DEPTH x N, one synchronous write port, one asynchronous read port); dmem_ctrl holds the FSM, counter and latches.

Verification
REQ-031 Store 0x00000000DEADBEEF to address 0x10 (LATENCY=2), then load 0x10: stall high for 3 cycles each, done in cycle 4, readData=0x00000000DEADBEEF.
REQ-032 Load address 0x10 + DEPTH*8: readData equals the word at 0x10 (wrap-around).
REQ-033 memRead=memWrite=1 with writeData=0x55 at 0x20: store committed, readData=0 at done; a later load of 0x20 returns 0x55.
REQ-034 Drop reset during the second ACCESS cycle of a store of 0xAA to 0x30: outputs return to 0 immediately; a subsequent load of 0x30 returns the old value.
REQ-035 With DMEM_ALIGN_CHECK_EN, store to 0x13: misalign=1 and done=1 in the same cycle, no write; without the macro, misalign stays 0 and word 2 is written.
REQ-036 Hold memRead high continuously for loads of 0x0, 0x8 and 0x10: done pulses every LATENCY+2 cycles, and stall drops only in RESP cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and defaults for the data-memory controller.
//   state_e     : controller FSM states (IDLE, ACCESS, RESP)
//   DEF_LATENCY : default number of ACCESS cycles per request
//   DEF_DEPTH   : default number of words in storage
//   CNT_W       : width of the access cycle counter (LATENCY up to 15)
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_DEPTH   = 64;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/dmem_if.sv
// dmem_if -- memory-stage <-> data-memory bus.
//   master : pipeline side; drives memRead/memWrite/address/writeData,
//            receives readData/stall/done/misalign
//   slave  : controller side (dmem_ctrl)
interface dmem_if #(parameter int N = 64);
  logic         memRead;
  logic         memWrite;
  logic [N-1:0] address;
  logic [N-1:0] writeData;
  logic [N-1:0] readData;
  logic         stall;
  logic         done;
  logic         misalign;

  modport master (output memRead, memWrite, address, writeData,
                  input  readData, stall, done, misalign);
  modport slave  (input  memRead, memWrite, address, writeData,
                  output readData, stall, done, misalign);
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram -- DEPTH x N word storage, never reset.
//   clk_i   : clock
//   we_i    : synchronous write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : asynchronous read word index
//   rdata_o : read data
module dmem_ram #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory controller (IDLE -> ACCESS x LATENCY -> RESP).
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : dmem_if.slave (memRead, memWrite, address, writeData in;
//           readData, stall, done, misalign out)
// Build option: define DMEM_ALIGN_CHECK_EN to reject accesses whose latched
// address[2:0] is non-zero (no store, readData 0, misalign raised with done).
// Assumes N > $clog2(DEPTH)+3 so there are ignored upper address bits.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int N       = 64,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_ACCESS = 2'(ACCESS);
  localparam logic [1:0] S_RESP   = 2'(RESP);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     addr_q, wdata_q;
  logic             wr_q;
  logic             req, accept, last_access, mis, we;
  logic [IW-1:0]    idx;
  logic [N-1:0]     rdata;

  assign req    = bus.memRead | bus.memWrite;
  assign accept = (state_q == S_IDLE) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_ACCESS;
        cnt_d   = CNT_W'(LATENCY - 1);
      end
      S_ACCESS: if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.address;
        wdata_q <= bus.writeData;
        // read+write together is a store
        wr_q    <= bus.memWrite;
      end
    end
  end

  assign idx         = addr_q[IW+2:3];
  assign last_access = (state_q == S_ACCESS) && (cnt_q == '0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (addr_q[2:0] != 3'd0);
  logic unused_addr;
  assign unused_addr = ^addr_q[N-1:IW+3];
`else
  assign mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr_q[N-1:IW+3], addr_q[2:0]};
`endif

  // Commit lands on the edge leaving ACCESS; an async reset before then
  // forces IDLE so the write never happens.
  assign we = last_access & wr_q & ~mis;

  dmem_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (idx),
    .wdata_i (wdata_q),
    .raddr_i (idx),
    .rdata_o (rdata)
  );

  assign bus.done     = (state_q == S_RESP);
  assign bus.misalign = (state_q == S_RESP) & mis;
  assign bus.readData = ((state_q == S_RESP) && !wr_q && !mis) ? rdata : '0;
  // Stall is combinational on the request so the pipeline freezes in the
  // request cycle itself; gated by reset so it stays low while in reset.
  assign bus.stall    = reset & (accept | (state_q == S_ACCESS));
endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    logic [N-1:0] rd;
    logic         mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cycle = 0;
  int   total = 0;
  int   passed = 0;
  int   last_done = 0;
  exp_t q[$];
  logic [N-1:0] mdl [DEPTH];

  dmem_if #(.N(N)) bus ();

  dmem_ctrl #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference model: word-addressed array, modulo-DEPTH index, stores
  // return 0, misaligned accesses rejected only in the checked build.
  task automatic model(input logic rd, input logic wr, input logic [N-1:0] a, input logic [N-1:0] wd);
    exp_t e;
    int   w;
    logic m;
    w = int'((a / 8) % DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    m = (a % 8) != 0;
`else
    m = 1'b0;
`endif
    e.mis = m;
    e.rd  = '0;
    if (wr) begin
      if (!m) mdl[w] = wd;
    end else if (rd && !m) begin
      e.rd = mdl[w];
    end
    q.push_back(e);
  endtask

  // mode 0: drop request after issue, 1: random junk during access, 2: hold
  task automatic do_req(input logic rd, input logic wr, input logic [N-1:0] a,
                        input logic [N-1:0] wd, input int mode);
    bit seen = 0;
    @(posedge clk); #1;
    bus.memRead = rd; bus.memWrite = wr; bus.address = a; bus.writeData = wd;
    model(rd, wr, a, wd);
    for (int k = 0; k < LAT + 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        chk("done_cycle", N'(k + 1), N'(LAT + 2));
        chk("stall_in_resp", N'(bus.stall), '0);
        last_done = cycle;
      end else begin
        if (k + 1 <= LAT + 1) chk("stall_busy", N'(bus.stall), N'(1));
        @(posedge clk); #1;
        if (mode == 1) begin
          bus.memRead   = 1'($urandom);
          bus.memWrite  = 1'($urandom);
          bus.address   = {$urandom, $urandom};
          bus.writeData = {$urandom, $urandom};
        end else if (mode == 0) begin
          bus.memRead = 1'b0; bus.memWrite = 1'b0;
        end
      end
    end
    if (!seen) chk("done_timeout", '0, N'(1));
    if (mode != 2) begin bus.memRead = 1'b0; bus.memWrite = 1'b0; end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", N'(1), '0);
      else begin
        e = q.pop_front();
        chk("readData", bus.readData, e.rd);
        chk("misalign", N'(bus.misalign), N'(e.mis));
      end
    end else if (bus.readData !== '0 || bus.misalign !== 1'b0) begin
      chk("outputs_zero_when_not_done", bus.readData | N'(bus.misalign), '0);
    end
  end

  initial begin
    int t0;
    logic [N-1:0] a;
    reset = 1'b0;
    bus.memRead = 1'b1; bus.memWrite = 1'b1;
    bus.address = '0; bus.writeData = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", N'(bus.stall), '0);
    chk("rst_done", N'(bus.done), '0);
    chk("rst_readData", bus.readData, '0);
    chk("rst_misalign", N'(bus.misalign), '0);
    bus.memRead = 1'b0; bus.memWrite = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // fill storage so every later load has a known expectation
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b0, 1'b1, N'(i * 8), {$urandom, $urandom}, 0);

    // store then load, and wrap-around load
    do_req(1'b0, 1'b1, N'('h10), N'('h00000000DEADBEEF), 0);
    do_req(1'b1, 1'b0, N'('h10), '0, 0);
    do_req(1'b1, 1'b0, N'('h10 + DEPTH * 8), '0, 0);

    // read+write together behaves as a store
    do_req(1'b1, 1'b1, N'('h20), N'('h55), 0);
    do_req(1'b1, 1'b0, N'('h20), '0, 0);

    // reset during the second ACCESS cycle aborts the store
    @(posedge clk); #1;
    bus.memWrite = 1'b1; bus.address = N'('h30); bus.writeData = N'('hAA);
    @(posedge clk); #1;
    bus.memWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_stall", N'(bus.stall), '0);
    chk("abort_done", N'(bus.done), '0);
    chk("abort_readData", bus.readData, '0);
    chk("abort_misalign", N'(bus.misalign), '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    do_req(1'b1, 1'b0, N'('h30), '0, 0);

    // misaligned store to 0x13 then read word 2 back
    do_req(1'b0, 1'b1, N'('h13), N'('h1234_5678_9ABC_DEF0), 0);
    do_req(1'b1, 1'b0, N'('h10), '0, 0);

    // memRead held: back-to-back loads
    do_req(1'b1, 1'b0, N'('h0), '0, 2);
    t0 = last_done;
    do_req(1'b1, 1'b0, N'('h8), '0, 2);
    chk("b2b_period1", N'(last_done - t0), N'(LAT + 2));
    t0 = last_done;
    do_req(1'b1, 1'b0, N'('h10), '0, 2);
    chk("b2b_period2", N'(last_done - t0), N'(LAT + 2));
    bus.memRead = 1'b0; bus.memWrite = 1'b0;

    // randomized traffic with junk on inputs while busy
    for (int i = 0; i < 150; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a[2:0] = 3'd0;
      case ($urandom_range(2))
        0: do_req(1'b1, 1'b0, a, {$urandom, $urandom}, 1);
        1: do_req(1'b0, 1'b1, a, {$urandom, $urandom}, 1);
        default: do_req(1'b1, 1'b1, a, {$urandom, $urandom}, 1);
      endcase
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", N'(q.size()), '0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
